// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 execute stage: ALU operation codes and
// hazard-unit forwarding selects.
package riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational RV32 ALU: add/sub/and/or/signed slt, with a zero flag for
// branch resolution.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    logic w_lt;

    assign w_lt = $signed(SrcA) < $signed(SrcB);

    // Unlisted operation codes deliberately yield 0 rather than a partial decode.
    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, w_lt};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// EX stage of the 5-stage RV32 pipeline: operand forwarding, ALU, branch/jump
// redirect and the EX/MEM pipeline register.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              ALUSrcE,
    input  logic              MemWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic [2:0]        ALUControlE,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [XLEN-1:0]   ResultW,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [REG_AW-1:0] RD_M,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M
);

    logic              r_reg_write;
    logic              r_mem_write;
    logic [1:0]        r_result_src;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_alu_result;
    logic [XLEN-1:0]   r_write_data;
    logic [XLEN-1:0]   r_pc_plus4;

    logic [XLEN-1:0]   w_src_a;
    logic [XLEN-1:0]   w_fwd_b;
    logic [XLEN-1:0]   w_src_b;
    logic [XLEN-1:0]   w_alu_result;
    logic              w_zero;

    // The reserved select 2'b11 falls through to the register-file value.
    always_comb begin
        w_src_a = RD1_E;
        case (ForwardAE)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = r_alu_result;
            default: w_src_a = RD1_E;
        endcase
    end

    always_comb begin
        w_fwd_b = RD2_E;
        case (ForwardBE)
            FWD_WB:  w_fwd_b = ResultW;
            FWD_MEM: w_fwd_b = r_alu_result;
            default: w_fwd_b = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

    alu #(
        .XLEN(XLEN)
    ) u_alu (
        .SrcA       (w_src_a),
        .SrcB       (w_src_b),
        .ALUControl (ALUControlE),
        .Result     (w_alu_result),
        .Zero       (w_zero)
    );

    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = (BranchE & w_zero) | JumpE;

    // Store data always comes from the forwarded B path, never the immediate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= 2'b00;
            r_rd         <= '0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
        end else begin
            r_reg_write  <= RegWriteE;
            r_mem_write  <= MemWriteE;
            r_result_src <= ResultSrcE;
            r_rd         <= RD_E;
            r_alu_result <= w_alu_result;
            r_write_data <= w_fwd_b;
            r_pc_plus4   <= PCPlus4E;
        end
    end

    assign RegWriteM  = r_reg_write;
    assign MemWriteM  = r_mem_write;
    assign ResultSrcM = r_result_src;
    assign RD_M       = r_rd;
    assign ALUResultM = r_alu_result;
    assign WriteDataM = r_write_data;
    assign PCPlus4M   = r_pc_plus4;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: directed vectors push expected EX/MEM
// contents and redirect values; monitors pop and compare.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    execute_cycle #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, mw;
        logic [1:0]  rsrc;
        logic        br, jmp, alusrc;
        logic [2:0]  op;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rd;
        logic [31:0] pc, pc4;
        logic [1:0]  fa, fb;
        logic [31:0] resw;
    } e_t;

    typedef struct packed {
        logic        rw, mw;
        logic [1:0]  rsrc;
        logic [4:0]  rd;
        logic [31:0] alu, wd, pc4;
    } m_t;

    typedef struct {
        string name;
        int    cyc;
        m_t    m;
    } mexp_t;

    typedef struct {
        string       name;
        logic        src;
        logic [31:0] tgt;
    } cexp_t;

    mexp_t mq[$];
    cexp_t cq[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    m_t    m_act;

    assign m_act = {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M};

    task automatic check_m(input string name, input m_t act, input m_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: M got rw=%b mw=%b rs=%b rd=%0d alu=%h wd=%h pc4=%h, expected rw=%b mw=%b rs=%b rd=%0d alu=%h wd=%h pc4=%h",
                     name, act.rw, act.mw, act.rsrc, act.rd, act.alu, act.wd, act.pc4,
                     exp.rw, exp.mw, exp.rsrc, exp.rd, exp.alu, exp.wd, exp.pc4);
        end
    endtask

    task automatic drive(input e_t e);
        RegWriteE = e.rw;   MemWriteE = e.mw;    ResultSrcE = e.rsrc;
        BranchE = e.br;     JumpE = e.jmp;       ALUSrcE = e.alusrc;
        ALUControlE = e.op; RD1_E = e.rd1;       RD2_E = e.rd2;
        Imm_Ext_E = e.imm;  RD_E = e.rd;         PCE = e.pc;
        PCPlus4E = e.pc4;   ForwardAE = e.fa;    ForwardBE = e.fb;
        ResultW = e.resw;
    endtask

    task automatic issue(input string name, input e_t e, input m_t m,
                         input logic src, input logic [31:0] tgt);
        drive(e);
        mq.push_back('{name, cyc + 1, m});
        cq.push_back('{name, src, tgt});
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        while (mq.size() > 0 && mq[0].cyc <= cyc) begin
            mexp_t x;
            x = mq.pop_front();
            check_m(x.name, m_act, x.m);
        end
    end

    initial forever begin
        @(negedge clk);
        while (cq.size() > 0) begin
            cexp_t c;
            c = cq.pop_front();
            checks++;
            if (PCSrcE !== c.src || PCTargetE !== c.tgt) begin
                failures++;
                $display("FAIL %s_redirect: got PCSrcE=%b PCTargetE=%h, expected PCSrcE=%b PCTargetE=%h",
                         c.name, PCSrcE, PCTargetE, c.src, c.tgt);
            end
        end
    end

    initial begin
        e_t e;
        m_t m;
        rst = 1'b0;
        drive('0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            e = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            drive(e);
            check_m("reset_hold", m_act, '0);
        end

        @(posedge clk); #1;
        rst = 1'b1;
        e = '0; e.rw = 1; e.rd = 1; e.rd1 = 5; e.rd2 = 7; e.pc4 = 32'h4;
        m = '{rw:1, mw:0, rsrc:0, rd:1, alu:12, wd:7, pc4:32'h4};
        issue("add_first", e, m, 0, 32'h0);

        @(posedge clk); #1;
        e = '0; e.rw = 1; e.rd = 2; e.op = 3'b001; e.fa = 2'b10; e.rd1 = 32'h999; e.rd2 = 2;
        e.pc = 32'h4; e.pc4 = 32'h8;
        m = '{rw:1, mw:0, rsrc:0, rd:2, alu:10, wd:2, pc4:32'h8};
        issue("sub_fwd_mem_a", e, m, 0, 32'h4);

        @(posedge clk); #1;
        e = '0; e.rw = 1; e.rd = 3; e.rsrc = 2'b01; e.op = 3'b011; e.rd1 = 3; e.rd2 = 32'h77;
        e.fb = 2'b01; e.resw = 32'h20; e.pc = 32'h8; e.pc4 = 32'hC;
        m = '{rw:1, mw:0, rsrc:2'b01, rd:3, alu:32'h23, wd:32'h20, pc4:32'hC};
        issue("or_fwd_wb_b", e, m, 0, 32'h8);

        @(posedge clk); #1;
        e = '0; e.mw = 1; e.alusrc = 1; e.imm = 8; e.rd1 = 32'h100; e.rd2 = 32'hDEAD;
        e.pc = 32'hC; e.pc4 = 32'h10;
        m = '{rw:0, mw:1, rsrc:0, rd:0, alu:32'h108, wd:32'hDEAD, pc4:32'h10};
        issue("store_imm", e, m, 0, 32'h14);

        @(posedge clk); #1;
        e = '0; e.br = 1; e.op = 3'b001; e.rd1 = 9; e.rd2 = 9; e.pc = 32'h40;
        e.imm = 32'hFFFF_FFF8; e.pc4 = 32'h44;
        m = '{rw:0, mw:0, rsrc:0, rd:0, alu:0, wd:9, pc4:32'h44};
        issue("beq_taken", e, m, 1, 32'h38);

        @(posedge clk); #1;
        e.rd2 = 8;
        m = '{rw:0, mw:0, rsrc:0, rd:0, alu:1, wd:8, pc4:32'h44};
        issue("beq_not_taken", e, m, 0, 32'h38);

        @(posedge clk); #1;
        e = '0; e.jmp = 1; e.rw = 1; e.rd = 1; e.rsrc = 2'b10; e.pc = 32'h10;
        e.imm = 32'h20; e.pc4 = 32'h14;
        m = '{rw:1, mw:0, rsrc:2'b10, rd:1, alu:0, wd:0, pc4:32'h14};
        issue("jal", e, m, 1, 32'h30);

        @(posedge clk); #1;
        e = '0; e.br = 1; e.rd1 = 32'hFFFF_FFFF; e.rd2 = 1; e.pc = 32'h100;
        m = '{rw:0, mw:0, rsrc:0, rd:0, alu:0, wd:1, pc4:0};
        issue("add_wrap", e, m, 1, 32'h100);

        @(posedge clk); #1;
        e = '0; e.br = 1; e.rw = 1; e.rd = 9; e.op = 3'b101; e.rd1 = 32'hFFFF_FFFF; e.rd2 = 1;
        m = '{rw:1, mw:0, rsrc:0, rd:9, alu:1, wd:1, pc4:0};
        issue("slt_neg_lt_pos", e, m, 0, 32'h0);

        @(posedge clk); #1;
        e = '0; e.op = 3'b101; e.rd1 = 1; e.rd2 = 32'hFFFF_FFFF;
        m = '{rw:0, mw:0, rsrc:0, rd:0, alu:0, wd:32'hFFFF_FFFF, pc4:0};
        issue("slt_pos_lt_neg", e, m, 0, 32'h0);

        @(posedge clk); #1;
        e = '0; e.br = 1; e.op = 3'b111; e.rd1 = 5; e.rd2 = 3; e.pc = 32'h200; e.imm = 4;
        m = '{rw:0, mw:0, rsrc:0, rd:0, alu:0, wd:3, pc4:0};
        issue("op_111", e, m, 1, 32'h204);

        @(posedge clk); #1;
        e = '0; e.fa = 2'b11; e.rd1 = 32'h11; e.resw = 32'h22; e.rd2 = 1;
        m = '{rw:0, mw:0, rsrc:0, rd:0, alu:32'h12, wd:1, pc4:0};
        issue("fwd_a_reserved", e, m, 0, 32'h0);

        @(posedge clk); #1;
        e = '0; e.op = 3'b010; e.rd1 = 32'hF0F0; e.rd2 = 32'hFF00;
        m = '{rw:0, mw:0, rsrc:0, rd:0, alu:32'hF000, wd:32'hFF00, pc4:0};
        issue("and", e, m, 0, 32'h0);

        @(posedge clk); #1;
        e = '0; e.op = 3'b010; e.fb = 2'b10; e.rd1 = 32'hF0FF; e.rd2 = 1; e.resw = 5;
        m = '{rw:0, mw:0, rsrc:0, rd:0, alu:32'hF000, wd:32'hF000, pc4:0};
        issue("and_fwd_mem_b", e, m, 0, 32'h0);

        @(posedge clk); #1;
        e = '0; e.mw = 1; e.alusrc = 1; e.imm = 4; e.rd1 = 32'h100; e.rd2 = 32'h55;
        e.fb = 2'b01; e.resw = 32'h77;
        m = '{rw:0, mw:1, rsrc:0, rd:0, alu:32'h104, wd:32'h77, pc4:0};
        issue("store_fwd_wb_data", e, m, 0, 32'h4);

        @(posedge clk); #1;
        issue("bubble", '0, '0, 0, 32'h0);

        @(posedge clk); #1;
        e = '0; e.rw = 1; e.rd = 5; e.rd1 = 1; e.rd2 = 2; e.pc4 = 32'h80;
        m = '{rw:1, mw:0, rsrc:0, rd:5, alu:3, wd:2, pc4:32'h80};
        issue("pre_reset", e, m, 0, 32'h0);

        @(posedge clk); #1;
        e = '0; e.rw = 1; e.rd = 6; e.rd1 = 32'h50; e.pc4 = 32'h84;
        drive(e);
        #3;
        rst = 1'b0;
        #1;
        check_m("reset_async", m_act, '0);
        @(posedge clk); #1;
        check_m("reset_held", m_act, '0);
        rst = 1'b1;
        e = '0; e.rw = 1; e.rd = 7; e.rd1 = 32'h1000; e.rd2 = 32'h234; e.pc4 = 32'h88;
        m = '{rw:1, mw:0, rsrc:0, rd:7, alu:32'h1234, wd:32'h234, pc4:32'h88};
        issue("after_reset", e, m, 0, 32'h0);

        @(posedge clk); #1;
        drive('0);
        @(posedge clk); #3;

        checks++;
        if (mq.size() != 0 || cq.size() != 0) begin
            failures++;
            $display("FAIL drain: pending M=%0d redirect=%0d, expected 0", mq.size(), cq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
EX stage of the 5-stage RV32 pipeline. It consumes the ID/EX register outputs of the decode stage, applies hazard-unit forwarding to both operands, and executes the ALU operation. It resolves branch and jump redirection and captures results in the EX/MEM pipeline register for the memory stage. The registered ALU result is also the M-stage forwarding source, fed back internally.

Parameters:
XLEN, 32, datapath width for operands, immediate, PC and results.
REG_AW, 5, register address width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
RegWriteE  in  1  register-write control from ID/EX.
ALUSrcE  in  1  1 selects Imm_Ext_E as ALU operand B.
MemWriteE  in  1  store control from ID/EX.
ResultSrcE  in  2  writeback select, passed through.
BranchE  in  1  conditional-branch (beq) instruction.
JumpE  in  1  jal instruction.
ALUControlE  in  3  ALU operation.
RD1_E, RD2_E  in  XLEN  register-file read data.
Imm_Ext_E  in  XLEN  sign-extended immediate.
RD_E  in  REG_AW  destination register.
PCE, PCPlus4E  in  XLEN  instruction PC and PC+4.
ForwardAE, ForwardBE  in  2  hazard-unit forwarding selects.
ResultW  in  XLEN  writeback-stage result, used for forwarding.
PCSrcE  out  1  redirect fetch (combinational).
PCTargetE  out  XLEN  redirect target (combinational).
RegWriteM, MemWriteM  out  1  registered controls.
ResultSrcM  out  2  registered writeback select.
RD_M  out  REG_AW  registered destination.
ALUResultM  out  XLEN  registered ALU result.
WriteDataM  out  XLEN  registered store data.
PCPlus4M  out  XLEN  registered PC+4.

Behaviour:
- Reset: rst low asynchronously clears every M output to 0 (RegWriteM=0, MemWriteM=0, ResultSrcM=2'b00, RD_M=0, ALUResultM=0, WriteDataM=0, PCPlus4M=0). A bubble therefore reaches MEM/WB after reset. Reset asserted mid-stream discards the in-flight instruction. The first capture occurs on the first rising edge after rst deasserts.
- Forwarding, SrcA from ForwardAE and forwarded-B from ForwardBE: 2'b00 selects RD1_E/RD2_E; 2'b01 selects ResultW; 2'b10 selects ALUResultM (the current register value); 2'b11 is reserved and behaves as 2'b00.
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded-B. WriteData always uses forwarded-B, never the immediate.
- ALU operations: 000 add; 001 sub; 010 and; 011 or; 101 slt (signed, result 1 or 0). All other codes produce 0. Add and sub wrap modulo 2^XLEN; there is no overflow flag.
- Zero = (ALU result == 0). PCSrcE = (BranchE & Zero) | JumpE.
- PCTargetE = PCE + Imm_Ext_E, wrapping modulo 2^XLEN. It is valid whenever PCSrcE=1 and otherwise don't-care, but it must remain deterministic.
- Latency: PCSrcE and PCTargetE are combinational in the same cycle. All M outputs update exactly 1 cycle after the E inputs.
- No stall or flush input exists. Squashing is done upstream by the decode register presenting zeroed controls. A zeroed-control instruction must yield RegWriteM=0 and MemWriteM=0.
- Back-to-back dependency: with ForwardAE=2'b10, the instruction in E sees the previous instruction's ALUResultM in the same cycle that the previous instruction sits in M.

Decomposition:
- Package riscv_pkg: ALU op localparams (ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101) and forward-select localparams (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
- One sub-module, alu: inputs SrcA, SrcB and ALUControl; outputs Result and Zero. It is purely combinational.
- Forwarding muxes, the branch adder and the EX/MEM register stay in execute_cycle.

Test Plan:
- Reset: hold rst=0 with random E inputs for 3 cycles -> all M outputs 0. Release rst, present add x1 (RD1_E=5, RD2_E=7, ALUSrcE=0, ALUControlE=000, RD_E=1, RegWriteE=1) -> next cycle ALUResultM=12, RD_M=1, RegWriteM=1.
- Forwarding: cycle n add gives ALUResultM=12. Cycle n+1: sub with ForwardAE=10, RD2_E=2 -> ALUResultM=10. Then ForwardBE=01 with ResultW=0x20, ALUSrcE=0, and 0x3 in SrcA -> or result 0x23.
- Immediate vs store data: ALUSrcE=1, Imm=8, RD1_E=0x100, RD2_E=0xDEAD, MemWriteE=1 -> ALUResultM=0x108, WriteDataM=0xDEAD, MemWriteM=1.
- Branch: BranchE=1 with RD1_E=RD2_E=9, sub, PCE=0x40, Imm=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0x38 in the same cycle. Repeat with RD2_E=8 -> PCSrcE=0. Jump: JumpE=1, PCE=0x10, Imm=0x20 -> PCSrcE=1, PCTargetE=0x30, PCPlus4M=0x14 next cycle.
- Arithmetic edges: add 0xFFFFFFFF+1 -> 0. slt with -1 < 1 -> 1. slt with 1 < -1 -> 0. ALUControlE=111 -> 0. ForwardAE=11 behaves as RD1_E.
- Reset mid-stream: assert rst asynchronously between edges while RegWriteM=1 -> outputs clear immediately, before the next clock edge.
